// File: rtl/mc_control_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/mem/writeback from the IR opcode.
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap opcodes 1001-1110 instead of treating them as NOPs.
module mc_control_fsm #(
    parameter int OPW   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_ld,
    output logic             pc_ld,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             reg_wr,
    output logic             wb_sel,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_R     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [1:0]       alu_fn_r;
    logic [CNT_W-1:0] instr_cnt_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ALU function captured at DECODE so EXEC_R outputs depend only on registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_fn_r <= 2'b00;
        end else if (state_r == S_DECODE) begin
            alu_fn_r <= opcode[1:0];
        end else begin
            alu_fn_r <= alu_fn_r;
        end
    end

    // Retired-instruction counter, bumped on each completed fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == S_FETCH) && mem_ready) begin
            instr_cnt_r <= instr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instr_cnt_r <= instr_cnt_r;
        end
    end

    assign instr_cnt = instr_cnt_r;

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:   state_nxt_s = S_FETCH;
            S_FETCH: begin
                if (mem_ready) state_nxt_s = S_DECODE;
                else           state_nxt_s = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    4'b0000, 4'b0001,
                    4'b0010, 4'b0011: state_nxt_s = S_EXEC_R;
                    4'b0100:          state_nxt_s = S_EXEC_I;
                    4'b0101, 4'b0110: state_nxt_s = S_MEM_ADDR;
                    4'b0111:          state_nxt_s = S_BRANCH;
                    4'b1000:          state_nxt_s = S_JUMP;
                    4'b1111:          state_nxt_s = S_HALT;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:          state_nxt_s = S_TRAP;
`else
                    default:          state_nxt_s = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R:   state_nxt_s = S_WB_R;
            S_EXEC_I:   state_nxt_s = S_WB_R;
            S_WB_R:     state_nxt_s = S_FETCH;
            S_MEM_ADDR: begin
                if (opcode == 4'b0101) state_nxt_s = S_MEM_RD;
                else                   state_nxt_s = S_MEM_WR;
            end
            S_MEM_RD: begin
                if (mem_ready) state_nxt_s = S_WB_MEM;
                else           state_nxt_s = S_MEM_RD;
            end
            S_MEM_WR: begin
                if (mem_ready) state_nxt_s = S_FETCH;
                else           state_nxt_s = S_MEM_WR;
            end
            S_WB_MEM: state_nxt_s = S_FETCH;
            S_BRANCH: state_nxt_s = S_FETCH;
            S_JUMP:   state_nxt_s = S_FETCH;
            S_HALT:   state_nxt_s = S_HALT;
            S_TRAP:   state_nxt_s = S_TRAP;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode from state (plus the mem_ready/zero qualifiers)
    always_comb begin
        ir_ld     = 1'b0;
        pc_ld     = 1'b0;
        pc_src    = 2'b00;
        iord      = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        reg_wr    = 1'b0;
        wb_sel    = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 3'b000;
        halted    = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_ld     = 1'b1;
                    pc_ld     = 1'b1;
                    alu_src_b = 2'b01;
                end else begin
                    alu_src_b = 2'b00;
                end
            end
            S_DECODE:   alu_src_b = 2'b10;
            S_EXEC_R:   alu_op = {1'b0, alu_fn_r};
            S_EXEC_I:   alu_src_b = 2'b10;
            S_WB_R:     reg_wr = 1'b1;
            S_MEM_ADDR: alu_src_b = 2'b10;
            S_MEM_RD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            S_MEM_WR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            S_WB_MEM: begin
                reg_wr = 1'b1;
                wb_sel = 1'b1;
            end
            S_BRANCH: begin
                alu_op = 3'b001;
                if (zero) begin
                    pc_ld  = 1'b1;
                    pc_src = 2'b10;
                end else begin
                    pc_ld  = 1'b0;
                end
            end
            S_JUMP: begin
                pc_ld  = 1'b1;
                pc_src = 2'b11;
            end
            S_HALT: halted = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: halted = 1'b1;
`endif
            default: halted = 1'b0;
        endcase
    end

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal = (state_r == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule
